mod_m_timer_arbiter: RTL
========================

# mod_m_timer_arbiter

Shares one prescaled down-counting timer among `R` requesters. A requester raises `req` with a tick count on its `load` slice. The block grants the timer round-robin, divides `clk` by `M` to form ticks, and counts the loaded value down. It pulses `done` to the owner on expiry. It sits between the mod-M tick counter datapath and the blocks that need timeouts or delays, so that each requester does not need its own counter.

## Interface
- `N`, 4: tick-count width.
- `M`, 10: prescaler modulus; one tick every `M` clk cycles; `M` ≥ 2.
- `R`, 4: number of requesters, 2..8.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req`  in  R  level request per requester; held until its `done`.
- `load`  in  R*N  packed counts; requester i uses bits [i*N +: N].
- `abort`  in  1  cancels the running timer; present only with `TIMER_ABORT_EN`.
- `gnt`  out  R  registered one-hot owner indication.
- `done`  out  R  registered one-cycle expiry pulse to the owner.
- `busy`  out  1  high whenever state ≠ IDLE.
- `count`  out  N  remaining ticks of the running timer.

## Operation
- FSM states: IDLE, RUN, DONE.
- Internal registers: `N`-bit count, `ceil(log2 M)`-bit prescaler, round-robin pointer `ptr` (index of last grantee).
- IDLE, with any `req` high:
  - Select the first requester searching `ptr+1, ptr+2, …` modulo `R`.
  - Set `ptr` to the winner and latch the winner's `load` slice into count.
  - Clear the prescaler and set the winner's `gnt` bit.
  - Next state is RUN, or DONE directly if the latched load is 0.
- RUN:
  - Prescaler counts 0..M-1 and wraps; a tick is the cycle with prescaler == M-1.
  - On a tick with count == 1, go to DONE and clear count to 0.
  - On a tick otherwise, decrement count.
  - Between ticks, count holds.
- DONE:
  - `done` bit of the owner is high for exactly this cycle; `gnt` stays high.
  - Next state is always IDLE, with `gnt` = 0.
- Requests:
  - Changes to `req` or `load` during RUN/DONE are ignored; the running timer always completes.
  - A non-owner `req` waits.
  - The owner must drop `req` in response to `done`. If it keeps `req` high, it re-arbitrates at lowest priority.
- Outputs: `count` reads 0 in IDLE. `gnt` and `done` are never multi-hot.
- Reset values: state IDLE, `ptr` = R-1 (so requester 0 wins first), all outputs 0.

## Timing
- Cycle 0 = IDLE cycle in which `req[i]` is sampled high with load L ≥ 1:
  - `gnt[i]` and `busy` high from cycle 1; count = L in cycle 1.
  - Ticks fall in cycles M, 2M, …; count changes on the edge after each tick.
  - `done[i]` is high in cycle L*M+1.
  - `gnt[i]` and `busy` are low in cycle L*M+2 (IDLE). The earliest next grant is visible in cycle L*M+3.
- L = 0: `gnt[i]` and `done[i]` are both high in cycle 1; IDLE in cycle 2.
- Maximum L = 2^N-1. There is no wrap; a count of 0 is never decremented.
- Reset asserted mid-RUN/DONE: all outputs go to 0 asynchronously. No `done` is issued and the pending grant is lost.

## Configuration
- `TIMER_ABORT_EN` defined:
  - `abort` port exists.
  - `abort` high in RUN: next cycle is IDLE, `gnt` = 0, count = 0, no `done` pulse.
  - `abort` in IDLE or DONE has no effect; DONE still pulses.
- `TIMER_ABORT_EN` undefined: no `abort` port; every granted timer runs to `done`.

## Test plan
- Reset: assert `reset` with `req` = 4'b1111 → `gnt`, `done`, `busy`, `count` all 0 while reset is high; first grant after release goes to requester 0.
- Single timer: M=10, `req[2]` high, load 3 at cycle 0 →
  - `gnt` = 4'b0100 from cycle 1; `count` reads 3, then 2 from cycle 11, then 1 from cycle 21;
  - `done` = 4'b0100 only in cycle 31; `busy` low in cycle 32.
- Round-robin: all `req` held high, all loads 1 → grant order 0,1,2,3,0; each `done` is M+1 cycles after its grant.
- Zero load: `req[1]`, load 0 → `gnt[1]` and `done[1]` both high in cycle 1 only; IDLE in cycle 2.
- Reset mid-run: reset in cycle 15 of a load-3 run → all outputs 0 immediately; no `done[i]` ever pulses for that run.
- Abort (`TIMER_ABORT_EN`): `abort` pulsed in cycle 5 of a load-3 run → `gnt` 0 and `busy` 0 in cycle 6; no `done` pulse; next requester granted in cycle 7.

Source files
------------

// File: rtl/mod_m_timer_arbiter.sv
// Round-robin shared prescaled down-counting timer: R requesters, one mod-M tick divider.
// Optional TIMER_ABORT_EN adds an abort input that cancels a running timer.
module mod_m_timer_arbiter #(
    parameter int N = 4,
    parameter int M = 10,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           reset,
`ifdef TIMER_ABORT_EN
    input  logic           abort,
`endif
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] load,
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   done,
    output logic           busy,
    output logic [N-1:0]   count
);
    localparam int PW    = (R > 1) ? $clog2(R) : 1;
    localparam int PRE_W = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, win_idx, idx;
    logic             win_vld;
    logic [N-1:0]     win_load;
    logic [R-1:0]     win_oh;
    logic [PRE_W-1:0] pre;
    logic [N-1:0]     cnt;
    logic             tick;
    logic             abort_run;

`ifdef TIMER_ABORT_EN
    assign abort_run = abort;
`else
    assign abort_run = 1'b0;
`endif

    // Search starts just past the last grantee, so it lands at lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        idx     = ptr;
        for (int k = 1; k <= R; k++) begin
            idx = PW'((int'(ptr) + k) % R);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign win_load = load[win_idx*N +: N];
    assign win_oh   = {{(R-1){1'b0}}, 1'b1} << win_idx;
    assign tick     = (pre == PRE_W'(M - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_vld) state_nxt = (win_load == '0) ? DONE : RUN;
            RUN: begin
                if (abort_run)                      state_nxt = IDLE;
                else if (tick && cnt == N'(1))      state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr  <= PW'(R - 1);
            pre  <= '0;
            cnt  <= '0;
            gnt  <= '0;
            done <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        ptr <= win_idx;
                        cnt <= win_load;
                        pre <= '0;
                        gnt <= win_oh;
                        if (win_load == '0) done <= win_oh;
                    end
                end
                RUN: begin
                    if (abort_run) begin
                        gnt <= '0;
                        cnt <= '0;
                        pre <= '0;
                    end else begin
                        pre <= tick ? '0 : pre + PRE_W'(1);
                        if (tick) begin
                            if (cnt == N'(1)) begin
                                cnt  <= '0;
                                done <= gnt;
                            end else if (cnt != '0) begin
                                cnt <= cnt - N'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    gnt <= '0;
                    cnt <= '0;
                end
                default: begin
                    gnt <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign count = cnt;
endmodule
